udma_eth_stream_bridge: RTL and testbench
=========================================

// Module: udma_eth_stream_bridge
// PURPOSE
// - Parametrised uDMA<->AXI-Stream framing bridge between the uDMA channel ports and the byte-wide MAC stream of udma_ethernet_top.
// - TX: fetches UDMA_WIDTH-bit words over uDMA req/gnt + valid/ready, serialises them little-endian onto 8-bit AXIS, and generates tlast from a programmed frame length.
// - RX: packs AXIS bytes into uDMA words (partial last word zero-padded), counts frame length and reports good/bad frames.
// PARAMETERS
// - UDMA_WIDTH  32  uDMA data width in bits, multiple of 8 (BPW = UDMA_WIDTH/8, 1..8)
// - LEN_WIDTH   16  frame length counter width in bytes
// - ERR_WIDTH   8   saturating RX bad-frame counter width
// PORTS
// - sys_clk_i       in  1           single clock
// - rstn_i          in  1           async reset, active low
// - tx_start_i      in  1           pulse: start one TX frame (ignored unless TX idle)
// - tx_len_i        in  LEN_WIDTH   TX frame length in bytes, sampled on accepted tx_start_i
// - tx_busy_o       out 1           TX FSM not IDLE
// - tx_done_o       out 1           1-cycle pulse at frame end
// - data_tx_req_o   out 1           uDMA TX word request
// - data_tx_gnt_i   in  1           uDMA TX grant
// - data_tx_i       in  UDMA_WIDTH  uDMA TX word
// - data_tx_valid_i in  1           uDMA TX word valid
// - data_tx_ready_o out 1           bridge accepts TX word
// - tx_axis_tdata_o/tvalid_o/tlast_o out 8/1/1  to MAC; tx_axis_tuser_o out 1 tied 0
// - tx_axis_tready_i in 1           MAC ready
// - rx_en_i         in  1           RX enable, sampled at first byte of each frame
// - rx_axis_tdata_i/tvalid_i/tlast_i/tuser_i in 8/1/1/1  from MAC (tuser=bad frame at tlast)
// - rx_axis_tready_o out 1          bridge ready
// - data_rx_o       out UDMA_WIDTH  packed RX word
// - data_rx_valid_o out 1           RX word valid
// - data_rx_ready_i in  1           uDMA accepts RX word
// - rx_frame_o      out 1           1-cycle pulse: frame completed (enabled frames only)
// - rx_bad_o        out 1           tuser at last tlast, held until next frame end
// - rx_len_o        out LEN_WIDTH   byte count of last completed frame
// - rx_err_cnt_o    out ERR_WIDTH   saturating count of bad frames
// BEHAVIOUR
// - Reset: all outputs 0; TX FSM IDLE; RX pack index 0; counters 0.
// - TX FSM: IDLE -start,len>0-> REQ; IDLE -start,len==0-> IDLE with tx_done_o next cycle, no AXIS beat.
//   REQ: data_tx_req_o=1 until data_tx_gnt_i -> WAIT. WAIT: data_tx_ready_o=1; on valid&ready latch word, byte idx=0 -> SEND.
//   SEND: tdata=word[8*idx+:8], tvalid=1; on tready: remaining--, idx++.
//   remaining==1 on handshake: tlast=1 on that beat -> DONE (tx_done_o=1, -> IDLE); unused upper bytes of last word dropped.
//   idx==BPW-1 on handshake (not last) -> REQ. tvalid stable and tdata unchanged until tready (AXIS rule).
// - TX latency: first tvalid 1 cycle after word accept; byte rate 1/cycle under continuous tready.
// - RX: rx_axis_tready_o = !data_rx_valid_o | data_rx_ready_i (1-entry output reg, full throughput).
//   Each accepted byte written to lane idx of pack reg; len++ (saturates at all-ones).
//   Word emitted (data_rx_valid_o=1, next cycle) when idx==BPW-1 or tlast; unused lanes zero; idx -> 0.
//   On tlast: rx_len_o=len (including the last byte), rx_bad_o=tuser, rx_frame_o pulse, err_cnt += tuser (saturating), len -> 0.
// - rx_en_i=0 at first byte: whole frame accepted (tready=1) and discarded; no words, no rx_frame_o, no counter update.
// - Simultaneous uDMA drain and new byte in: both happen, no bubble.
// - Async reset mid-frame: all state cleared; a partial TX frame is truncated with no tlast; the MAC must treat it as aborted.
// STRUCTURE
// - udma_eth_pkg: typedef enum {TX_IDLE, TX_REQ, TX_WAIT, TX_SEND, TX_DONE} tx_state_e; localparam BPW function.
// - One sub-module: udma_eth_rx_packer (RX byte->word packing and status); TX FSM stays in the top.
// TESTING
// - len=6, BPW=4, words 0x44332211,0x88776655, tready=1 -> bytes 11..66, tlast on 66, 2 req/gnt, tx_done_o 1 pulse.
// - len=0 start -> no req, no tvalid, tx_done_o 1 cycle later; start while busy -> ignored, frame unchanged.
// - TX tready toggled every other cycle -> tdata/tvalid stable while stalled, byte order intact.
// - RX 5 bytes 01..05, tlast, tuser=0 -> words 0x04030201, 0x00000005; rx_len_o=5, rx_frame_o pulse.
// - RX data_rx_ready_i=0 for 10 cycles mid-frame -> tready drops, no byte loss; tuser=1 frame -> rx_bad_o=1, err_cnt=1.
// - rx_en_i=0 frame of 8 bytes -> no data_rx_valid_o, no rx_frame_o; async reset mid-TX -> outputs 0, FSM IDLE.

Source files
------------

// File: rtl/udma_eth_pkg.sv
// rtl/udma_eth_pkg.sv - shared types and helpers for the uDMA <-> byte-stream bridge
// Purpose: TX FSM state encoding and the bytes-per-word helper used by the
//          bridge top and the RX packer.
// Ports:   none (package).
package udma_eth_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_REQ,
    TX_WAIT,
    TX_SEND,
    TX_DONE
  } tx_state_e;

  // Bytes carried by one uDMA word.
  function automatic int udma_bpw(input int udma_width);
    return udma_width / 8;
  endfunction

endpackage

// File: rtl/udma_eth_rx_packer.sv
// rtl/udma_eth_rx_packer.sv - packs received stream bytes into uDMA words and reports frame status
// Purpose: accepts bytes from the MAC, writes them little-endian into a word,
//          emits the word through a 1-entry output register, and tracks frame
//          length, bad-frame flag and a saturating bad-frame counter.
// Ports:   clk_i/rstn_i             clock, async active-low reset
//          tdata_i/tvalid_i/tlast_i/tuser_i/tready_o  byte stream from the MAC
//          rx_en_i                  frame enable, sampled at the first byte
//          data_o/valid_o/ready_i   packed word towards the uDMA
//          frame_o/bad_o/len_o/err_cnt_o  frame status
module udma_eth_rx_packer
  import udma_eth_pkg::*;
#(
  parameter int UDMA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [7:0]            tdata_i,
  input  logic                  tvalid_i,
  input  logic                  tlast_i,
  input  logic                  tuser_i,
  output logic                  tready_o,
  input  logic                  rx_en_i,
  output logic [UDMA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_o,
  output logic                  bad_o,
  output logic [LEN_WIDTH-1:0]  len_o,
  output logic [ERR_WIDTH-1:0]  err_cnt_o
);

  localparam int BPW   = udma_bpw(UDMA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [UDMA_WIDTH-1:0] pack_q, pack_next, data_q;
  logic [IDX_W-1:0]      idx_q;
  logic [LEN_WIDTH-1:0]  len_q, len_inc, len_out_q;
  logic [ERR_WIDTH-1:0]  err_q, err_inc;
  logic                  valid_q, frame_q, bad_q;
  logic                  in_frame_q, frame_en_q;
  logic                  accept, cur_en, last_lane;

  // Output register drains and refills in the same cycle, so no bubble.
  assign tready_o  = !valid_q || ready_i;
  assign accept    = tvalid_i && tready_o;
  // Enable is decided at the first byte and held for the rest of the frame.
  assign cur_en    = in_frame_q ? frame_en_q : rx_en_i;
  assign last_lane = (idx_q == IDX_W'(BPW - 1));
  assign len_inc   = (&len_q) ? len_q : len_q + 1'b1;
  assign err_inc   = (&err_q) ? err_q : err_q + 1'b1;

  always_comb begin
    pack_next = pack_q;
    for (int b = 0; b < BPW; b++) begin
      if (idx_q == IDX_W'(b)) pack_next[8*b +: 8] = tdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pack_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      len_out_q  <= '0;
      err_q      <= '0;
      valid_q    <= 1'b0;
      frame_q    <= 1'b0;
      bad_q      <= 1'b0;
      in_frame_q <= 1'b0;
      frame_en_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (valid_q && ready_i) valid_q <= 1'b0;
      if (accept) begin
        in_frame_q <= !tlast_i;
        if (!in_frame_q) frame_en_q <= rx_en_i;
        if (cur_en) begin
          // Pack register is cleared on every emit, so unused lanes are zero.
          if (tlast_i || last_lane) begin
            data_q  <= pack_next;
            valid_q <= 1'b1;
            pack_q  <= '0;
            idx_q   <= '0;
          end else begin
            pack_q <= pack_next;
            idx_q  <= idx_q + 1'b1;
          end
          if (tlast_i) begin
            len_out_q <= len_inc;
            bad_q     <= tuser_i;
            frame_q   <= 1'b1;
            len_q     <= '0;
            if (tuser_i) err_q <= err_inc;
          end else begin
            len_q <= len_inc;
          end
        end
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign frame_o   = frame_q;
  assign bad_o     = bad_q;
  assign len_o     = len_out_q;
  assign err_cnt_o = err_q;

endmodule

// File: rtl/udma_eth_stream_bridge.sv
// rtl/udma_eth_stream_bridge.sv - uDMA word channel <-> 8-bit MAC stream framing bridge
// Purpose: TX fetches uDMA words and serialises them little-endian onto the
//          byte stream with tlast from a programmed length; RX packs bytes
//          into uDMA words via udma_eth_rx_packer.
// Ports:   sys_clk_i/rstn_i                      clock, async active-low reset
//          tx_start_i/tx_len_i/tx_busy_o/tx_done_o  TX frame control
//          data_tx_req_o/gnt_i/data_tx_i/valid_i/ready_o  uDMA TX channel
//          tx_axis_*                               byte stream to the MAC
//          rx_en_i, rx_axis_*                      byte stream from the MAC
//          data_rx_o/valid_o/ready_i               uDMA RX channel
//          rx_frame_o/rx_bad_o/rx_len_o/rx_err_cnt_o  RX frame status
module udma_eth_stream_bridge
  import udma_eth_pkg::*;
#(
  parameter int UDMA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  sys_clk_i,
  input  logic                  rstn_i,
  input  logic                  tx_start_i,
  input  logic [LEN_WIDTH-1:0]  tx_len_i,
  output logic                  tx_busy_o,
  output logic                  tx_done_o,
  output logic                  data_tx_req_o,
  input  logic                  data_tx_gnt_i,
  input  logic [UDMA_WIDTH-1:0] data_tx_i,
  input  logic                  data_tx_valid_i,
  output logic                  data_tx_ready_o,
  output logic [7:0]            tx_axis_tdata_o,
  output logic                  tx_axis_tvalid_o,
  output logic                  tx_axis_tlast_o,
  output logic                  tx_axis_tuser_o,
  input  logic                  tx_axis_tready_i,
  input  logic                  rx_en_i,
  input  logic [7:0]            rx_axis_tdata_i,
  input  logic                  rx_axis_tvalid_i,
  input  logic                  rx_axis_tlast_i,
  input  logic                  rx_axis_tuser_i,
  output logic                  rx_axis_tready_o,
  output logic [UDMA_WIDTH-1:0] data_rx_o,
  output logic                  data_rx_valid_o,
  input  logic                  data_rx_ready_i,
  output logic                  rx_frame_o,
  output logic                  rx_bad_o,
  output logic [LEN_WIDTH-1:0]  rx_len_o,
  output logic [ERR_WIDTH-1:0]  rx_err_cnt_o
);

  localparam int BPW   = udma_bpw(UDMA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  tx_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [UDMA_WIDTH-1:0] word_q, word_d;
  logic                  zero_done_q, zero_done_d;
  logic [7:0]            tx_byte;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= TX_IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      zero_done_q <= zero_done_d;
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    for (int b = 0; b < BPW; b++) begin
      if (idx_q == IDX_W'(b)) tx_byte = word_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d          = state_q;
    remaining_d      = remaining_q;
    idx_d            = idx_q;
    word_d           = word_q;
    zero_done_d      = 1'b0;
    data_tx_req_o    = 1'b0;
    data_tx_ready_o  = 1'b0;
    tx_axis_tvalid_o = 1'b0;
    tx_axis_tlast_o  = 1'b0;
    tx_axis_tdata_o  = 8'h00;
    // A zero-length start completes without leaving IDLE.
    tx_done_o        = zero_done_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_start_i) begin
          if (tx_len_i != '0) begin
            remaining_d = tx_len_i;
            state_d     = TX_REQ;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      TX_REQ: begin
        data_tx_req_o = 1'b1;
        if (data_tx_gnt_i) state_d = TX_WAIT;
      end
      TX_WAIT: begin
        data_tx_ready_o = 1'b1;
        if (data_tx_valid_i) begin
          word_d  = data_tx_i;
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_axis_tvalid_o = 1'b1;
        tx_axis_tdata_o  = tx_byte;
        tx_axis_tlast_o  = (remaining_q == LEN_WIDTH'(1));
        if (tx_axis_tready_i) begin
          remaining_d = remaining_q - 1'b1;
          idx_d       = idx_q + 1'b1;
          // Frame end wins over word end; leftover bytes of the last word are dropped.
          if (remaining_q == LEN_WIDTH'(1)) state_d = TX_DONE;
          else if (idx_q == IDX_W'(BPW - 1)) state_d = TX_REQ;
        end
      end
      TX_DONE: begin
        tx_done_o = 1'b1;
        state_d   = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_busy_o       = (state_q != TX_IDLE);
  assign tx_axis_tuser_o = 1'b0;

  udma_eth_rx_packer #(
    .UDMA_WIDTH (UDMA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .ERR_WIDTH  (ERR_WIDTH)
  ) u_rx_packer (
    .clk_i     (sys_clk_i),
    .rstn_i    (rstn_i),
    .tdata_i   (rx_axis_tdata_i),
    .tvalid_i  (rx_axis_tvalid_i),
    .tlast_i   (rx_axis_tlast_i),
    .tuser_i   (rx_axis_tuser_i),
    .tready_o  (rx_axis_tready_o),
    .rx_en_i   (rx_en_i),
    .data_o    (data_rx_o),
    .valid_o   (data_rx_valid_o),
    .ready_i   (data_rx_ready_i),
    .frame_o   (rx_frame_o),
    .bad_o     (rx_bad_o),
    .len_o     (rx_len_o),
    .err_cnt_o (rx_err_cnt_o)
  );

endmodule

// File: tb/tb_udma_eth_stream_bridge.sv
// tb/tb_udma_eth_stream_bridge.sv - scoreboard bench for udma_eth_stream_bridge
module tb_udma_eth_stream_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [15:0] tx_len = '0;
  logic        tx_busy, tx_done;
  logic        tx_req, tx_gnt, tx_dvalid, tx_dready;
  logic [31:0] tx_data;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid, tx_tlast, tx_tuser, tx_tready;
  logic        rx_en = 1'b1;
  logic [7:0]  rx_tdata = '0;
  logic        rx_tvalid = 1'b0, rx_tlast = 1'b0, rx_tuser = 1'b0;
  logic        rx_tready;
  logic [31:0] rx_data;
  logic        rx_dvalid;
  logic        rx_dready = 1'b1;
  logic        rx_frame, rx_bad;
  logic [15:0] rx_len;
  logic [7:0]  rx_err;

  always #5 clk = ~clk;

  udma_eth_stream_bridge #(.UDMA_WIDTH(32), .LEN_WIDTH(16), .ERR_WIDTH(8)) dut (
    .sys_clk_i(clk), .rstn_i(rst_n),
    .tx_start_i(tx_start), .tx_len_i(tx_len), .tx_busy_o(tx_busy), .tx_done_o(tx_done),
    .data_tx_req_o(tx_req), .data_tx_gnt_i(tx_gnt), .data_tx_i(tx_data),
    .data_tx_valid_i(tx_dvalid), .data_tx_ready_o(tx_dready),
    .tx_axis_tdata_o(tx_tdata), .tx_axis_tvalid_o(tx_tvalid), .tx_axis_tlast_o(tx_tlast),
    .tx_axis_tuser_o(tx_tuser), .tx_axis_tready_i(tx_tready),
    .rx_en_i(rx_en), .rx_axis_tdata_i(rx_tdata), .rx_axis_tvalid_i(rx_tvalid),
    .rx_axis_tlast_i(rx_tlast), .rx_axis_tuser_i(rx_tuser), .rx_axis_tready_o(rx_tready),
    .data_rx_o(rx_data), .data_rx_valid_o(rx_dvalid), .data_rx_ready_i(rx_dready),
    .rx_frame_o(rx_frame), .rx_bad_o(rx_bad), .rx_len_o(rx_len), .rx_err_cnt_o(rx_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { logic [15:0] len; logic bad; } frame_t;
  beat_t       tx_exp[$];
  logic [31:0] tx_words[$];
  logic [31:0] rx_exp[$];
  frame_t      fr_exp[$];

  int   gnt_cnt = 0, done_cnt = 0, frame_cnt = 0;
  bit   tready_toggle = 0;
  bit   saw_rx_stall = 0;

  // uDMA TX source and MAC tready driver; inputs change 1 time unit after the edge.
  initial begin
    logic [31:0] tmp;
    tx_gnt = 0; tx_dvalid = 0; tx_data = '0; tx_tready = 1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        tx_gnt = 0; tx_dvalid = 0;
      end else begin
        if (tx_dvalid && tx_words.size() != 0) tmp = tx_words.pop_front();
        tx_gnt = tx_req;
        if (tx_req) gnt_cnt++;
        if (tx_dready && tx_words.size() != 0) begin
          tx_dvalid = 1; tx_data = tx_words[0];
        end else begin
          tx_dvalid = 0;
        end
        tx_tready = tready_toggle ? !tx_tready : 1'b1;
      end
    end
  end

  // TX monitor: compares every accepted beat against the scoreboard.
  logic       stall_prev = 0;
  logic [7:0] prev_d = '0;
  beat_t      te;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("tx_stall_tvalid", tx_tvalid, 1);
        check("tx_stall_tdata", tx_tdata, prev_d);
      end
      if (tx_tvalid && tx_tready) begin
        check("tx_beat_expected", tx_exp.size() != 0, 1);
        if (tx_exp.size() != 0) begin
          te = tx_exp.pop_front();
          check("tx_tdata", tx_tdata, te.d);
          check("tx_tlast", tx_tlast, te.l);
        end
      end
      stall_prev = tx_tvalid && !tx_tready;
      prev_d = tx_tdata;
      if (tx_done) done_cnt++;
    end else begin
      stall_prev = 0;
    end
  end

  // RX monitor: words and frame status.
  frame_t fe;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_tvalid && !rx_tready) saw_rx_stall = 1;
      if (rx_dvalid && rx_dready) begin
        check("rx_word_expected", rx_exp.size() != 0, 1);
        if (rx_exp.size() != 0) check("rx_word", rx_data, rx_exp.pop_front());
      end
      if (rx_frame) begin
        frame_cnt++;
        check("rx_frame_expected", fr_exp.size() != 0, 1);
        if (fr_exp.size() != 0) begin
          fe = fr_exp.pop_front();
          check("rx_len", rx_len, fe.len);
          check("rx_bad", rx_bad, fe.bad);
        end
      end
    end
  end

  task automatic push_beats(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      beat_t x;
      x.d = b[i]; x.l = (i == b.size() - 1);
      tx_exp.push_back(x);
    end
  endtask

  task automatic start_tx(input logic [15:0] len);
    @(posedge clk); #1; tx_start = 1; tx_len = len;
    @(posedge clk); #1; tx_start = 0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    @(negedge clk);
    while (tx_busy && n < 300) begin @(negedge clk); n++; end
    check("tx_finish", tx_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic last, input logic user);
    int n = 0;
    @(posedge clk); #1;
    rx_tvalid = 1; rx_tdata = d; rx_tlast = last; rx_tuser = user;
    @(negedge clk);
    while (!rx_tready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("rx_tready_timeout", rx_tready, 1);
  endtask

  task automatic rx_idle();
    @(posedge clk); #1; rx_tvalid = 0; rx_tlast = 0; rx_tuser = 0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, d0, f0;
    frame_t fr;
    logic [7:0] bq[$];

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_tvalid", tx_tvalid, 0);
    check("rst_rx_dvalid", rx_dvalid, 0);
    check("rst_rx_len", rx_len, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_tx_tuser", tx_tuser, 0);
    @(negedge clk); rst_n = 1;

    // TX len=6 across two words; a start while busy must be ignored
    g0 = gnt_cnt; d0 = done_cnt;
    tx_words.push_back(32'h44332211); tx_words.push_back(32'h88776655);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    push_beats(bq);
    start_tx(16'd6);
    repeat (2) @(posedge clk);
    start_tx(16'd3);
    wait_tx_idle();
    check("tx6_grants", gnt_cnt - g0, 2);
    check("tx6_done_pulses", done_cnt - d0, 1);
    check("tx6_beats_left", tx_exp.size(), 0);

    // Zero-length start
    g0 = gnt_cnt; d0 = done_cnt;
    start_tx(16'd0);
    check("len0_done_pulse", tx_done, 1);
    check("len0_busy", tx_busy, 0);
    @(posedge clk); #1;
    check("len0_done_single", tx_done, 0);
    repeat (3) @(posedge clk); #1;
    check("len0_no_grant", gnt_cnt - g0, 0);
    check("len0_done_count", done_cnt - d0, 1);

    // TX with tready toggling; upper byte of last word dropped
    g0 = gnt_cnt;
    tready_toggle = 1;
    tx_words.push_back(32'hDDCCBBAA); tx_words.push_back(32'h4411FFEE);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11};
    push_beats(bq);
    start_tx(16'd7);
    wait_tx_idle();
    tready_toggle = 0;
    check("tx7_grants", gnt_cnt - g0, 2);
    check("tx7_beats_left", tx_exp.size(), 0);

    // RX 5 bytes, good frame
    f0 = frame_cnt;
    rx_exp.push_back(32'h04030201); rx_exp.push_back(32'h00000005);
    fr.len = 16'd5; fr.bad = 0; fr_exp.push_back(fr);
    for (int i = 1; i <= 5; i++) rx_byte(8'(i), i == 5, 0);
    rx_idle();
    check("rx5_frames", frame_cnt - f0, 1);
    check("rx5_err", rx_err, 0);

    // RX 9 bytes, bad frame, uDMA stalls 10 cycles mid-frame
    f0 = frame_cnt;
    rx_exp.push_back(32'h13121110); rx_exp.push_back(32'h17161514); rx_exp.push_back(32'h00000018);
    fr.len = 16'd9; fr.bad = 1; fr_exp.push_back(fr);
    fork
      begin
        repeat (4) @(posedge clk); #1; rx_dready = 0;
        repeat (10) @(posedge clk); #1; rx_dready = 1;
      end
      begin
        for (int i = 0; i < 9; i++) rx_byte(8'h10 + 8'(i), i == 8, i == 8);
      end
    join
    rx_idle();
    check("rx9_tready_dropped", saw_rx_stall, 1);
    check("rx9_frames", frame_cnt - f0, 1);
    check("rx9_err", rx_err, 1);
    check("rx9_bad_held", rx_bad, 1);

    // Disabled frame: enable raised mid-frame must not take effect
    f0 = frame_cnt;
    rx_en = 0;
    for (int i = 0; i < 8; i++) begin
      rx_byte(8'hA0 + 8'(i), i == 7, i == 7);
      if (i == 2) rx_en = 1;
    end
    rx_idle();
    check("rxdis_frames", frame_cnt - f0, 0);
    check("rxdis_len_kept", rx_len, 9);
    check("rxdis_err_kept", rx_err, 1);
    check("rxdis_bad_kept", rx_bad, 1);

    // Async reset in the middle of a TX frame
    tx_words.push_back(32'h04030201); tx_words.push_back(32'h08070605); tx_words.push_back(32'h0C0B0A09);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    push_beats(bq);
    start_tx(16'd12);
    repeat (7) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("arst_tvalid", tx_tvalid, 0);
    check("arst_busy", tx_busy, 0);
    check("arst_req", tx_req, 0);
    check("arst_tlast", tx_tlast, 0);
    check("arst_rx_len", rx_len, 0);
    check("arst_rx_err", rx_err, 0);
    check("arst_rx_bad", rx_bad, 0);
    tx_exp.delete(); tx_words.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;

    // Recovery: one-byte frame
    tx_words.push_back(32'h000000A5);
    bq = '{8'hA5};
    push_beats(bq);
    start_tx(16'd1);
    wait_tx_idle();

    check("end_tx_queue", tx_exp.size(), 0);
    check("end_rx_queue", rx_exp.size(), 0);
    check("end_frame_queue", fr_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
